// File: rtl/vga_pkg.sv
// Shared VGA display-stage definitions: timing constants, motion direction
// and motion state types, and the per-axis bounce step used by vga_box_mover.
package vga_pkg;

  localparam int unsigned H_ACT   = 800;
  localparam int unsigned V_ACT   = 600;
  localparam int unsigned H_TOTAL = 1040;
  localparam int unsigned V_TOTAL = 666;
  localparam int unsigned HSYNC   = 120;
  localparam int unsigned VSYNC   = 6;

  typedef enum logic {
    POS = 1'b0,
    NEG = 1'b1
  } dir_t;

  typedef enum logic {
    RUN   = 1'b0,
    PAUSE = 1'b1
  } motion_t;

  typedef struct packed {
    logic [9:0] pos;
    dir_t       dir;
  } axis_t;

  // One frame of motion on one axis. Arithmetic is 11 bits wide so pos+spd
  // never wraps; landing exactly on a wall flips direction in the same step.
  function automatic axis_t axis_step(input logic [9:0]  pos,
                                      input dir_t        dir,
                                      input logic [2:0]  spd,
                                      input logic [10:0] max_pos);
    logic [10:0] sum;
    axis_t       r;
    r.pos = pos;
    r.dir = dir;
    sum   = {1'b0, pos} + {8'b0, spd};
    if (dir == POS) begin
      if (sum >= max_pos) begin
        r.pos = max_pos[9:0];
        r.dir = NEG;
      end else begin
        r.pos = sum[9:0];
      end
    end else begin
      if ({1'b0, pos} <= {8'b0, spd}) begin
        r.pos = '0;
        r.dir = POS;
      end else begin
        r.pos = pos - {7'b0, spd};
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/vga_box_mover_key_debounce.sv
// key_debounce: 2-FF synchronizer plus press detector for one raw active-low
// push-button. Emits a one-cycle press_o pulse per physical press.
// VGA_BOX_DEBOUNCE_EN defined: IDLE/ARM/HELD/REL debounce FSM with a DB_CYC
// stable time. Undefined: press_o fires on the falling edge of the
// synchronized key (3 cycles of latency), for simulation or debounced keys.
module key_debounce #(
  parameter int unsigned DB_CYC = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n_i,
  output logic press_o
);

  logic sync1_q;
  logic sync2_q;
  logic press_q;

  if (DB_CYC < 1) begin : g_db_cyc_check
    $error("key_debounce: DB_CYC must be at least 1");
  end

  // Two-flop synchronizer; keys idle high so reset to 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= key_n_i;
      sync2_q <= sync1_q;
    end
  end

`ifdef VGA_BOX_DEBOUNCE_EN
  localparam int unsigned          CNT_W    = (DB_CYC > 1) ? $clog2(DB_CYC) : 1;
  localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(DB_CYC - 1);

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    HELD,
    REL
  } db_state_t;

  db_state_t        state_q;
  logic [CNT_W-1:0] cnt_q;

  // Debounce FSM: a press needs DB_CYC stable-low cycles, a release DB_CYC
  // stable-high cycles; bounces during release fall back to HELD silently.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      press_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (!sync2_q) begin
            state_q <= ARM;
            cnt_q   <= '0;
          end
        end
        ARM: begin
          if (sync2_q) begin
            state_q <= IDLE;
          end else if (cnt_q == CNT_LAST) begin
            state_q <= HELD;
            press_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        HELD: begin
          if (sync2_q) begin
            state_q <= REL;
            cnt_q   <= '0;
          end
        end
        REL: begin
          if (!sync2_q) begin
            state_q <= HELD;
          end else if (cnt_q == CNT_LAST) begin
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
`else
  logic sync3_q;

  // Falling-edge detector on the synchronized key.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync3_q <= 1'b1;
      press_q <= 1'b0;
    end else begin
      sync3_q <= sync2_q;
      press_q <= sync3_q & ~sync2_q;
    end
  end
`endif

  assign press_o = press_q;

endmodule

// File: rtl/vga_box_mover.sv
// vga_box_mover: per-frame position generator for the 30x30 box drawn by the
// 800x600 display stage. On each vsync rising edge (vertical back porch) the
// box steps by `speed` pixels per axis and bounces off the active-area walls.
// Two buttons cycle the speed 1..SPEED_MAX and toggle pause.
// Build option: define VGA_BOX_DEBOUNCE_EN to enable the key debounce FSM.
module vga_box_mover
  import vga_pkg::*;
#(
  parameter int unsigned H_ACT     = 800,
  parameter int unsigned V_ACT     = 600,
  parameter int unsigned BOX_W     = 30,
  parameter int unsigned BOX_H     = 30,
  parameter int unsigned SPEED_MAX = 7,
  parameter int unsigned DB_CYC    = 1_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       vsync,
  input  logic       key_speed_n,
  input  logic       key_pause_n,
  output logic [9:0] box_x,
  output logic [9:0] box_y,
  output logic [2:0] speed,
  output logic       paused,
  output logic       upd
);

  localparam logic [10:0] X_MAX   = 11'(H_ACT - BOX_W);
  localparam logic [10:0] Y_MAX   = 11'(V_ACT - BOX_H);
  localparam logic [9:0]  X_RST   = 10'((H_ACT - BOX_W) / 2);
  localparam logic [9:0]  Y_RST   = 10'((V_ACT - BOX_H) / 2);
  localparam logic [2:0]  SPD_TOP = 3'(SPEED_MAX);

  if (SPEED_MAX < 1 || SPEED_MAX > 7) begin : g_speed_check
    $error("vga_box_mover: SPEED_MAX must be in 1..7");
  end

  logic    speed_press;
  logic    pause_press;

  motion_t    state_q;
  dir_t       dx_q;
  dir_t       dy_q;
  logic [9:0] x_q;
  logic [9:0] y_q;
  logic [2:0] spd_q;
  logic       upd_q;
  logic       vsync_prev_q;  // delayed vsync (vsync_d), resets high
  logic       tick_q;

  axis_t nx_d;
  axis_t ny_d;

  key_debounce #(
    .DB_CYC(DB_CYC)
  ) u_key_speed (
    .clk    (clk),
    .rst_n  (rst_n),
    .key_n_i(key_speed_n),
    .press_o(speed_press)
  );

  key_debounce #(
    .DB_CYC(DB_CYC)
  ) u_key_pause (
    .clk    (clk),
    .rst_n  (rst_n),
    .key_n_i(key_pause_n),
    .press_o(pause_press)
  );

  // Candidate next position for both axes at the current speed.
  always_comb begin
    nx_d = axis_step(x_q, dx_q, spd_q, X_MAX);
    ny_d = axis_step(y_q, dy_q, spd_q, Y_MAX);
  end

  // Motion FSM: registered frame tick, move on tick in RUN, pause toggling
  // and speed cycling. Moves always use the speed/state held before this edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= RUN;
      dx_q         <= POS;
      dy_q         <= POS;
      x_q          <= X_RST;
      y_q          <= Y_RST;
      spd_q        <= 3'd1;
      upd_q        <= 1'b0;
      vsync_prev_q <= 1'b1;
      tick_q       <= 1'b0;
    end else begin
      vsync_prev_q <= vsync;
      tick_q       <= vsync & ~vsync_prev_q;
      upd_q        <= 1'b0;
      case (state_q)
        RUN: begin
          if (tick_q) begin
            x_q   <= nx_d.pos;
            dx_q  <= nx_d.dir;
            y_q   <= ny_d.pos;
            dy_q  <= ny_d.dir;
            upd_q <= 1'b1;
          end
          if (pause_press) state_q <= PAUSE;
        end
        PAUSE: begin
          if (pause_press) state_q <= RUN;
        end
        default: state_q <= RUN;
      endcase
      if (speed_press) begin
        spd_q <= (spd_q >= SPD_TOP) ? 3'd1 : spd_q + 3'd1;
      end
    end
  end

  assign box_x  = x_q;
  assign box_y  = y_q;
  assign speed  = spd_q;
  assign paused = (state_q == PAUSE);
  assign upd    = upd_q;

endmodule

// File: tb/tb_vga_box_mover.sv
// Scoreboard bench for vga_box_mover. Stimulus pushes expected moves and
// expected speed/pause changes; a negedge monitor pops and compares on every
// upd pulse and every speed/paused change. Debounce-specific vectors are
// included when VGA_BOX_DEBOUNCE_EN is defined.
`timescale 1ns/1ps
module tb_vga_box_mover;

  localparam int unsigned DB = 100;
`ifdef VGA_BOX_DEBOUNCE_EN
  localparam int unsigned LAT  = DB + 4;  // key-low drive edge to action edge
  localparam int unsigned HOLD = 150;
`else
  localparam int unsigned LAT  = 4;
  localparam int unsigned HOLD = 10;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       vsync = 1'b0;
  logic       key_speed_n = 1'b1;
  logic       key_pause_n = 1'b1;
  logic [9:0] box_x;
  logic [9:0] box_y;
  logic [2:0] speed;
  logic       paused;
  logic       upd;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
  } pos_t;

  typedef struct packed {
    logic [2:0] spd;
    logic       p;
  } key_t;

  pos_t mq[$];
  key_t kq[$];
  pos_t pe;
  key_t ke;

  int n_cmp = 0;
  int n_bad = 0;

  int mx, my, mdx, mdy, mspd, mpaused;
  logic [2:0] prev_spd;
  logic       prev_p;

  vga_box_mover #(
    .H_ACT    (800),
    .V_ACT    (600),
    .BOX_W    (30),
    .BOX_H    (30),
    .SPEED_MAX(7),
    .DB_CYC   (DB)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .vsync      (vsync),
    .key_speed_n(key_speed_n),
    .key_pause_n(key_pause_n),
    .box_x      (box_x),
    .box_y      (box_y),
    .speed      (speed),
    .paused     (paused),
    .upd        (upd)
  );

  always #10 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mx = 385; my = 285; mdx = 1; mdy = 1; mspd = 1; mpaused = 0;
  endtask

  task automatic model_axis(inout int p, inout int d, input int s, input int lim);
    if (d > 0) begin
      if (p + s >= lim) begin p = lim; d = -1; end
      else p = p + s;
    end else begin
      if (p <= s) begin p = 0; d = 1; end
      else p = p - s;
    end
  endtask

  task automatic model_move();
    if (mpaused == 0) begin
      model_axis(mx, mdx, mspd, 770);
      model_axis(my, mdy, mspd, 570);
      mq.push_back('{x: 10'(mx), y: 10'(my)});
    end
  endtask

  task automatic model_key(input int which);
    if (which == 0) mspd = (mspd == 7) ? 1 : mspd + 1;
    else mpaused = (mpaused == 0) ? 1 : 0;
    kq.push_back('{spd: 3'(mspd), p: 1'(mpaused)});
  endtask

  task automatic set_key(input int which, input logic v);
    if (which == 0) key_speed_n = v;
    else key_pause_n = v;
  endtask

  task automatic tick();
    model_move();
    @(posedge clk); #1 vsync = 1'b1;
    repeat (3) @(posedge clk);
    #1 vsync = 1'b0;
    repeat (3) @(posedge clk);
  endtask

  task automatic press(input int which);
    model_key(which);
    @(posedge clk); #1 set_key(which, 1'b0);
    repeat (HOLD) @(posedge clk);
    #1 set_key(which, 1'b1);
    repeat (HOLD) @(posedge clk);
  endtask

  // Press whose action lands on the same edge as a frame tick's move.
  task automatic press_with_tick(input int which);
    model_move();
    model_key(which);
    @(posedge clk); #1 set_key(which, 1'b0);
    repeat (LAT - 2) @(posedge clk);
    #1 vsync = 1'b1;
    repeat (3) @(posedge clk);
    #1 vsync = 1'b0;
    repeat (HOLD - LAT + 2) @(posedge clk);
    #1 set_key(which, 1'b1);
    repeat (HOLD) @(posedge clk);
  endtask

  // Monitor: pops expectations whenever the DUT presents a move or key effect.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_spd = speed;
      prev_p   = paused;
    end else begin
      if (upd === 1'b1) begin
        if (mq.size() == 0) begin
          check("unexpected_upd", 1, 0);
        end else begin
          pe = mq.pop_front();
          check("box_x", int'(box_x), int'(pe.x));
          check("box_y", int'(box_y), int'(pe.y));
        end
      end
      if (speed !== prev_spd || paused !== prev_p) begin
        if (kq.size() == 0) begin
          check("unexpected_key_effect", 1, 0);
        end else begin
          ke = kq.pop_front();
          check("speed", int'(speed), int'(ke.spd));
          check("paused", int'(paused), int'(ke.p));
        end
        prev_spd = speed;
        prev_p   = paused;
      end
    end
  end

  initial begin
    repeat (60000) @(posedge clk);
    $display("FAIL watchdog: run exceeded 60000 cycles, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #1 check("rst_box_x", int'(box_x), 385);
    check("rst_box_y", int'(box_y), 285);
    check("rst_speed", int'(speed), 1);
    check("rst_paused", int'(paused), 0);
    check("rst_upd", int'(upd), 0);
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1 check("idle_box_x", int'(box_x), 385);
    check("idle_box_y", int'(box_y), 285);

    // First tick: upd exactly 2 cycles after the vsync rise, one cycle wide.
    mq.push_back('{x: 10'd386, y: 10'd286});
    mx = 386; my = 286;
    @(posedge clk); #1 vsync = 1'b1;
    @(posedge clk); #1 check("upd_lat1", int'(upd), 0);
    @(posedge clk); #1 check("upd_lat2", int'(upd), 1);
    @(posedge clk); #1 check("upd_width", int'(upd), 0);
    vsync = 1'b0;
    repeat (3) @(posedge clk);

    // Seven presses wrap 2..7,1; six more reach 7.
    for (int i = 0; i < 13; i++) press(0);

    // Speed 7 from (386,286): tick 55 -> (770,472), tick 56 -> (763,465).
    for (int i = 0; i < 55; i++) tick();
    #1 check("wall_x", int'(box_x), 770);
    check("wall_y", int'(box_y), 472);
    tick();
    #1 check("bounce_x", int'(box_x), 763);
    check("bounce_y", int'(box_y), 465);
    // Continue through exact landings on 0 and 770.
    for (int i = 0; i < 150; i++) tick();

    // Pause freezes motion, second press resumes.
    press(1);
    for (int i = 0; i < 3; i++) tick();
    #1 check("paused_x", int'(box_x), mx);
    check("paused_y", int'(box_y), my);
    press(1);
    tick();

    // Simultaneous events.
    press_with_tick(0);  // move at speed 7, then speed -> 1
    press_with_tick(1);  // RUN -> PAUSE, last move happens
    press_with_tick(1);  // PAUSE -> RUN, no move this frame
    tick();

`ifdef VGA_BOX_DEBOUNCE_EN
    // 50-cycle glitch: no press.
    @(posedge clk); #1 key_speed_n = 1'b0;
    repeat (50) @(posedge clk);
    #1 key_speed_n = 1'b1;
    repeat (HOLD) @(posedge clk);
    // 150-cycle press with a 10-cycle bounce on release: one press.
    model_key(0);
    @(posedge clk); #1 key_speed_n = 1'b0;
    repeat (150) @(posedge clk);
    #1 key_speed_n = 1'b1;
    repeat (10) @(posedge clk);
    #1 key_speed_n = 1'b0;
    repeat (10) @(posedge clk);
    #1 key_speed_n = 1'b1;
    repeat (HOLD) @(posedge clk);
`endif

    // Reset mid-frame with vsync high: no tick on release.
    repeat (10) @(posedge clk);
    #1 vsync = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 check("mid_rst_box_x", int'(box_x), 385);
    check("mid_rst_box_y", int'(box_y), 285);
    check("mid_rst_speed", int'(speed), 1);
    check("mid_rst_paused", int'(paused), 0);
    rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1 vsync = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    tick();

    repeat (10) @(posedge clk);
    check("pending_moves", mq.size(), 0);
    check("pending_keys", kq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
